// File: rtl/line_double_buffer_if.sv
// Timing, render-write and display bundle for the scanline buffer.
// master drives timing/render inputs; slave is the buffer itself.
interface line_double_buffer_if #(
   parameter int DW = 8
);

   logic          clk_pix;
   logic [8:0]    hc;
   logic [8:0]    vc;
   logic          hbl;
   logic          vbl;

   logic          wr_en;
   logic [8:0]    wr_x;
   logic [DW-1:0] wr_data;

   logic          ready;
   logic          line_start;
   logic [8:0]    line_num;
   logic [DW-1:0] pix_out;
   logic          late_wr;

   modport master (
      output clk_pix, hc, vc, hbl, vbl,
      output wr_en, wr_x, wr_data,
      input  ready, line_start, line_num,
      input  pix_out, late_wr
   );

   modport slave (
      input  clk_pix, hc, vc, hbl, vbl,
      input  wr_en, wr_x, wr_data,
      output ready, line_start, line_num,
      output pix_out, late_wr
   );

endinterface

// File: rtl/line_double_buffer.sv
// Ping-pong scanline buffer: render fills one bank while the other
// is shown at hc and cleared behind the beam; banks swap at hblank.
module line_double_buffer #(
   parameter int            DW          = 8,
   parameter int            WIDTH       = 256,
   parameter logic [DW-1:0] TRANSPARENT = '0,
   parameter bit            SKIP_TRANS  = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   line_double_buffer_if.slave bus
);

   localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [9:0] WLIM = 10'(WIDTH);
   localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]    state;
   logic [AW-1:0] clr_addr;
   logic          bank_sel;
   logic          hbl_q;

   logic          ready_q;
   logic          line_start_q;
   logic [8:0]    line_num_q;
   logic [DW-1:0] pix_q;
   logic          late_q;

   logic [DW-1:0] bank0 [WIDTH];
   logic [DW-1:0] bank1 [WIDTH];

   logic          running;
   logic          hc_vis;
   logic          wx_vis;
   logic          swap;
   logic          rd_en;
   logic          skip;
   logic          wr_ok;
   logic [AW-1:0] hc_a;
   logic [AW-1:0] wx_a;
   logic [DW-1:0] rd_data;

   logic          we0;
   logic          we1;
   logic [AW-1:0] wa0;
   logic [AW-1:0] wa1;
   logic [DW-1:0] wd0;
   logic [DW-1:0] wd1;

   assign running = (state == ST_RUN);
   assign hc_vis  = ({1'b0, bus.hc} < WLIM);
   assign wx_vis  = ({1'b0, bus.wr_x} < WLIM);
   assign hc_a    = bus.hc[AW-1:0];
   assign wx_a    = bus.wr_x[AW-1:0];

   assign swap  = running & bus.clk_pix & bus.hbl & ~hbl_q;
   assign rd_en = running & bus.clk_pix & hc_vis;
   assign skip  = SKIP_TRANS && (bus.wr_data == TRANSPARENT);

   // A write landing on the swap clk has no well-defined target line.
   assign wr_ok = running & bus.wr_en & wx_vis & ~skip & ~swap;

   assign rd_data = bank_sel ? bank1[hc_a] : bank0[hc_a];

   // Each bank sees at most one write per clk: clear, display-clear
   // or render, so the two banks never contend.
   always_comb begin
      we0 = 1'b0;
      we1 = 1'b0;
      wa0 = '0;
      wa1 = '0;
      wd0 = TRANSPARENT;
      wd1 = TRANSPARENT;
      if (!reset) begin
         if (state == ST_CLEAR) begin
            we0 = 1'b1;
            we1 = 1'b1;
            wa0 = clr_addr;
            wa1 = clr_addr;
         end else if (bank_sel) begin
            we1 = rd_en;
            wa1 = hc_a;
            we0 = wr_ok;
            wa0 = wx_a;
            wd0 = bus.wr_data;
         end else begin
            we0 = rd_en;
            wa0 = hc_a;
            we1 = wr_ok;
            wa1 = wx_a;
            wd1 = bus.wr_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we0) bank0[wa0] <= wd0;
      if (we1) bank1[wa1] <= wd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_CLEAR;
         clr_addr     <= '0;
         bank_sel     <= 1'b0;
         hbl_q        <= 1'b1;
         ready_q      <= 1'b0;
         line_start_q <= 1'b0;
         line_num_q   <= '0;
         pix_q        <= TRANSPARENT;
         late_q       <= 1'b0;
      end else begin
         line_start_q <= swap;
         if (bus.clk_pix) hbl_q <= bus.hbl;
         case (state)
            ST_CLEAR: begin
               clr_addr <= clr_addr + 1'b1;
               if (clr_addr == LAST) begin
                  state   <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               if (swap) begin
                  bank_sel   <= ~bank_sel;
                  line_num_q <= bus.vc + 9'd1;
               end
               if (swap & bus.wr_en) late_q <= 1'b1;
               if (bus.clk_pix) begin
                  if (hc_vis & ~bus.hbl & ~bus.vbl)
                     pix_q <= rd_data;
                  else
                     pix_q <= TRANSPARENT;
               end
            end
         endcase
      end
   end

   assign bus.ready      = ready_q;
   assign bus.line_start = line_start_q;
   assign bus.line_num   = line_num_q;
   assign bus.pix_out    = pix_q;
   assign bus.late_wr    = late_q;

endmodule

// File: tb/tb_line_double_buffer.sv
// Directed bench for line_double_buffer: clear, swap, display,
// clear-on-read, late writes, vblank and mid-line reset.
module tb_line_double_buffer;

   localparam int DW    = 8;
   localparam int WIDTH = 256;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   line_double_buffer_if #(.DW(DW)) bus ();

   line_double_buffer #(
      .DW(DW),
      .WIDTH(WIDTH),
      .TRANSPARENT(8'h00),
      .SKIP_TRANS(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [7:0] exp_line [WIDTH];

   typedef struct {
      logic [8:0] wr_x;
      logic [7:0] wr_data;
      logic [8:0] chk_x;
      logic [7:0] chk_pix;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clear_exp();
      for (int i = 0; i < WIDTH; i++) exp_line[i] = 8'h00;
   endtask

   task automatic pix(input logic [8:0] h, input logic [8:0] v,
                      input logic hb, input logic vb);
      @(negedge clk);
      bus.clk_pix = 1'b1;
      bus.hc      = h;
      bus.vc      = v;
      bus.hbl     = hb;
      bus.vbl     = vb;
      @(negedge clk);
      bus.clk_pix = 1'b0;
   endtask

   task automatic wr(input logic [8:0] x, input logic [7:0] d);
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_x    = x;
      bus.wr_data = d;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n;
      int bad;
      n   = 0;
      bad = 0;
      while (n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.line_start !== 1'b0 || bus.pix_out !== 8'h00) bad++;
         if (bus.ready === 1'b1) break;
         bus.clk_pix = 1'b1;
         bus.hbl     = ~bus.hbl;
      end
      bus.clk_pix = 1'b0;
      bus.hbl     = 1'b0;
      chk({tag, "_clear_len"}, n, 256);
      chk({tag, "_clear_quiet"}, bad, 0);
      chk({tag, "_ready"}, bus.ready, 1);
   endtask

   task automatic do_swap(input logic [8:0] v, input logic vb,
                          input logic [8:0] exp_num);
      pix(9'd400, v, 1'b0, vb);
      chk("blank_pix", bus.pix_out, 0);
      pix(9'd400, v, 1'b1, vb);
      chk("swap_pulse", bus.line_start, 1);
      chk("swap_line_num", bus.line_num, exp_num);
      @(posedge clk);
      #1;
      chk("swap_pulse_end", bus.line_start, 0);
   endtask

   task automatic scan(input logic vb, input string tag);
      for (int h = 0; h < WIDTH; h++) begin
         pix(9'(h), 9'd0, 1'b0, vb);
         chk($sformatf("%s_x%0d", tag, h), bus.pix_out,
             vb ? 8'h00 : exp_line[h]);
      end
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{9'd10,  8'h5A, 9'd10,  8'h5A};
      vecs[1] = '{9'd255, 8'h33, 9'd255, 8'h33};
      vecs[2] = '{9'd4,   8'h7F, 9'd4,   8'h7F};
      vecs[3] = '{9'd4,   8'h00, 9'd4,   8'h7F};
      vecs[4] = '{9'd300, 8'h77, 9'd44,  8'h00};
      vecs[5] = '{9'd20,  8'h11, 9'd20,  8'h22};
      vecs[6] = '{9'd20,  8'h22, 9'd20,  8'h22};
      vecs[7] = '{9'd0,   8'h01, 9'd0,   8'h01};

      reset       = 1'b1;
      bus.clk_pix = 1'b0;
      bus.hc      = '0;
      bus.vc      = '0;
      bus.hbl     = 1'b0;
      bus.vbl     = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_x    = '0;
      bus.wr_data = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", bus.ready, 0);
      chk("rst_line_start", bus.line_start, 0);
      chk("rst_line_num", bus.line_num, 0);
      chk("rst_pix_out", bus.pix_out, 0);
      chk("rst_late_wr", bus.late_wr, 0);
      @(negedge clk);
      reset = 1'b0;
      wait_ready("init");

      for (int i = 0; i < 8; i++) wr(vecs[i].wr_x, vecs[i].wr_data);
      do_swap(9'd20, 1'b0, 9'd21);
      clear_exp();
      for (int i = 0; i < 8; i++) exp_line[vecs[i].chk_x] = vecs[i].chk_pix;
      scan(1'b0, "l21");

      clear_exp();
      do_swap(9'd21, 1'b0, 9'd22);
      scan(1'b0, "l22");
      do_swap(9'd22, 1'b0, 9'd23);
      scan(1'b0, "l23_reread");
      chk("late_wr_idle", bus.late_wr, 0);

      pix(9'd400, 9'd23, 1'b0, 1'b0);
      @(negedge clk);
      bus.clk_pix = 1'b1;
      bus.hc      = 9'd400;
      bus.vc      = 9'd23;
      bus.hbl     = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_x    = 9'd3;
      bus.wr_data = 8'h11;
      @(negedge clk);
      bus.clk_pix = 1'b0;
      bus.wr_en   = 1'b0;
      chk("late_swap_pulse", bus.line_start, 1);
      chk("late_line_num", bus.line_num, 24);
      chk("late_wr_set", bus.late_wr, 1);
      scan(1'b0, "l24_late");
      do_swap(9'd24, 1'b0, 9'd25);
      scan(1'b0, "l25_late");
      chk("late_wr_sticky", bus.late_wr, 1);

      wr(9'd7, 8'h66);
      do_swap(9'd511, 1'b1, 9'd0);
      scan(1'b1, "vbl_l0");
      wr(9'd9, 8'h55);
      do_swap(9'd15, 1'b1, 9'd16);
      exp_line[9] = 8'h55;
      scan(1'b0, "l16");

      clear_exp();
      wr(9'd50, 8'h44);
      for (int h = 0; h < 60; h++) pix(9'(h), 9'd16, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_ready", bus.ready, 0);
      chk("mid_rst_late_wr", bus.late_wr, 0);
      chk("mid_rst_pix_out", bus.pix_out, 0);
      @(negedge clk);
      reset = 1'b0;
      wait_ready("rerun");
      do_swap(9'd100, 1'b0, 9'd101);
      scan(1'b0, "post_rst_a");
      do_swap(9'd101, 1'b0, 9'd102);
      scan(1'b0, "post_rst_b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
